// File: rtl/td4x_core.sv
// td4x_core: TD4-class accumulator CPU with writable program memory,
// SUB/JZ/HLT extensions, execute enable and a valid/ready output register.
module td4x_core #(
    parameter int DW = 4,
    parameter int AW = 4,
    localparam int IW = 4 + DW
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          CE,
    input  logic [DW-1:0] IN,
    output logic [DW-1:0] OUT,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    input  logic          START,
    output logic          HALTED,
    output logic [AW-1:0] PC_O,
    input  logic          PROG_WE,
    input  logic [AW-1:0] PROG_ADDR,
    input  logic [IW-1:0] PROG_DATA
);

    typedef enum logic {RUN, HALT} state_t;

    typedef enum logic [3:0] {
        OP_ADD_A = 4'b0000, OP_MOV_AB = 4'b0001, OP_IN_A  = 4'b0010, OP_MOV_AI = 4'b0011,
        OP_MOV_BA = 4'b0100, OP_ADD_B = 4'b0101, OP_IN_B  = 4'b0110, OP_MOV_BI = 4'b0111,
        OP_SUB_A = 4'b1000, OP_OUT_B = 4'b1001, OP_JZ    = 4'b1010, OP_OUT_I  = 4'b1011,
        OP_NOP   = 4'b1100, OP_HLT   = 4'b1101, OP_JNC   = 4'b1110, OP_JMP    = 4'b1111
    } op_t;

    logic [IW-1:0] rom [2**AW];

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic          c_q, c_d, z_q, z_d, ov_q, ov_d;

    logic [IW-1:0] instr;
    op_t           op;
    logic [DW-1:0] im, src, im_eff;
    logic [DW:0]   sum;
    logic          is_sub, is_out, stall, retire;

    // Program memory has no reset: the loader owns its content.
    always_ff @(posedge CLOCK) begin
        if (PROG_WE) begin
            rom[PROG_ADDR] <= PROG_DATA;
        end
    end

    always_comb begin
        instr  = rom[pc_q];
        op     = op_t'(instr[IW-1:DW]);
        im     = instr[DW-1:0];
        is_sub = (op == OP_SUB_A);
        is_out = (op == OP_OUT_B) || (op == OP_OUT_I);

        src = '0;
        case (op)
            OP_ADD_A, OP_SUB_A, OP_MOV_BA: src = a_q;
            OP_MOV_AB, OP_ADD_B, OP_OUT_B: src = b_q;
            OP_IN_A, OP_IN_B:              src = IN;
            default:                       src = '0;
        endcase

        // Subtract as A + ~IM + 1 so the carry out reads as "no borrow".
        im_eff = is_sub ? ~im : im;
        sum    = {1'b0, src} + {1'b0, im_eff} + {{DW{1'b0}}, is_sub};

        stall  = is_out && ov_q && !OUT_READY;
        retire = (state_q == RUN) && CE && !stall;

        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        z_d     = z_q;
        out_d   = out_q;
        ov_d    = OUT_READY ? 1'b0 : ov_q;

        case (state_q)
            RUN: begin
                if (retire) begin
                    pc_d = pc_q + AW'(1);
                    if (op != OP_NOP && op != OP_HLT) begin
                        c_d = sum[DW];
                        z_d = (sum[DW-1:0] == '0);
                    end
                    case (op)
                        OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI, OP_SUB_A: a_d = sum[DW-1:0];
                        OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI:           b_d = sum[DW-1:0];
                        OP_OUT_B, OP_OUT_I: begin
                            out_d = sum[DW-1:0];
                            ov_d  = 1'b1;
                        end
                        OP_JNC: if (!c_q) pc_d = im[AW-1:0];
                        OP_JZ:  if (z_q)  pc_d = im[AW-1:0];
                        OP_JMP: pc_d = im[AW-1:0];
                        OP_HLT: begin
                            pc_d    = pc_q;
                            state_d = HALT;
                        end
                        default: ;
                    endcase
                end
            end
            HALT: begin
                if (START) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= RUN;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            z_q     <= z_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = ov_q;
    assign HALTED    = (state_q == HALT);
    assign PC_O      = pc_q;

endmodule

// File: tb/tb_td4x_core.sv
// Bench for td4x_core: a 4/4 and an 8/6 instance stepped against an
// instruction-level reference model, plus directed program scenarios.
module tb_td4x_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, ce4, rdy4, st4, we4, ov4, h4;
    logic [3:0] in4, wa4, out4, pc4;
    logic [7:0] wd4;

    logic        rst8, ce8, rdy8, st8, we8, ov8, h8;
    logic [7:0]  in8, out8;
    logic [5:0]  wa8, pc8;
    logic [11:0] wd8;

    td4x_core #(.DW(4), .AW(4)) u_d4 (
        .CLOCK(clk), .RESET(rst4), .CE(ce4), .IN(in4), .OUT(out4), .OUT_VALID(ov4),
        .OUT_READY(rdy4), .START(st4), .HALTED(h4), .PC_O(pc4),
        .PROG_WE(we4), .PROG_ADDR(wa4), .PROG_DATA(wd4)
    );

    td4x_core #(.DW(8), .AW(6)) u_d8 (
        .CLOCK(clk), .RESET(rst8), .CE(ce8), .IN(in8), .OUT(out8), .OUT_VALID(ov8),
        .OUT_READY(rdy8), .START(st8), .HALTED(h8), .PC_O(pc8),
        .PROG_WE(we8), .PROG_ADDR(wa8), .PROG_DATA(wd8)
    );

    typedef struct {
        int unsigned a, b, c, z, out, ov, pc, halted;
    } mst_t;

    mst_t        m4, m8;
    int unsigned rom4 [16];
    int unsigned rom8 [64];
    int unsigned p4 [16];
    int unsigned p8 [64];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural effect of one clock edge, straight from the instruction rules.
    function automatic mst_t model(input mst_t s, input int unsigned word, input int unsigned dw,
                                   input int unsigned aw, input bit rst, input bit ce,
                                   input int unsigned inp, input bit rdy, input bit start);
        mst_t        n;
        int unsigned mask, amask, op, im, src, sum, r;
        mask  = (1 << dw) - 1;
        amask = (1 << aw) - 1;
        n = s;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (s.halted != 0) begin
            if (start) begin
                n.halted = 0;
                n.pc     = 0;
            end
            if (rdy) n.ov = 0;
            return n;
        end
        if (!ce) begin
            if (rdy) n.ov = 0;
            return n;
        end
        op = (word >> dw) & 15;
        im = word & mask;
        if ((op == 9 || op == 11) && s.ov != 0 && !rdy) return n;
        if (rdy) n.ov = 0;
        case (op)
            0, 4, 8: src = s.a;
            1, 5, 9: src = s.b;
            2, 6:    src = inp;
            default: src = 0;
        endcase
        if (op == 8) sum = src + ((~im) & mask) + 1;
        else         sum = src + im;
        r    = sum & mask;
        n.pc = (s.pc + 1) & amask;
        if (op != 12 && op != 13) begin
            n.c = (sum >> dw) & 1;
            n.z = (r == 0) ? 1 : 0;
        end
        case (op)
            0, 1, 2, 3, 8: n.a = r;
            4, 5, 6, 7:    n.b = r;
            9, 11: begin
                n.out = r;
                n.ov  = 1;
            end
            10: if (s.z != 0) n.pc = im & amask;
            14: if (s.c == 0) n.pc = im & amask;
            15: n.pc = im & amask;
            13: begin
                n.pc     = s.pc;
                n.halted = 1;
            end
            default: ;
        endcase
        return n;
    endfunction

    task automatic tick();
        mst_t n4, n8;
        n4 = model(m4, rom4[m4.pc], 4, 4, rst4, ce4, 32'(in4), rdy4, st4);
        n8 = model(m8, rom8[m8.pc], 8, 6, rst8, ce8, 32'(in8), rdy8, st8);
        @(posedge clk);
        #1;
        if (we4) rom4[wa4] = 32'(wd4);
        if (we8) rom8[wa8] = 32'(wd8);
        m4 = n4;
        m8 = n8;
        check("d4_pc",  32'(pc4),       m4.pc);
        check("d4_out", 32'(out4),      m4.out);
        check("d4_ov",  32'(ov4),       m4.ov);
        check("d4_hlt", 32'(h4),        m4.halted);
        check("d4_a",   32'(u_d4.a_q),  m4.a);
        check("d4_b",   32'(u_d4.b_q),  m4.b);
        check("d4_c",   32'(u_d4.c_q),  m4.c);
        check("d4_z",   32'(u_d4.z_q),  m4.z);
        check("d8_pc",  32'(pc8),       m8.pc);
        check("d8_out", 32'(out8),      m8.out);
        check("d8_ov",  32'(ov8),       m8.ov);
        check("d8_hlt", 32'(h8),        m8.halted);
        check("d8_a",   32'(u_d8.a_q),  m8.a);
        check("d8_b",   32'(u_d8.b_q),  m8.b);
        check("d8_c",   32'(u_d8.c_q),  m8.c);
        check("d8_z",   32'(u_d8.z_q),  m8.z);
    endtask

    task automatic load4();
        ce4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            we4 = 1'b1;
            wa4 = 4'(i);
            wd4 = 8'(p4[i]);
            tick();
        end
        we4 = 1'b0;
    endtask

    task automatic load8();
        ce8 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            we8 = 1'b1;
            wa8 = 6'(i);
            wd8 = 12'(p8[i]);
            tick();
        end
        we8 = 1'b0;
    endtask

    task automatic reset4();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
    endtask

    initial begin
        int unsigned got_q [$];
        int unsigned exp_q [$];
        logic [3:0]  prev;
        int unsigned changes;

        m4 = '{default: 0};
        m8 = '{default: 0};
        foreach (rom4[i]) rom4[i] = 0;
        foreach (rom8[i]) rom8[i] = 0;
        {ce4, st4, we4, in4, wa4, wd4} = '0;
        {ce8, st8, we8, in8, wa8, wd8} = '0;
        rdy4 = 1'b1;
        rdy8 = 1'b1;
        rst4 = 1'b1;
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        check("rst_pc",  32'(pc4),  0);
        check("rst_ov",  32'(ov4),  0);
        check("rst_out", 32'(out4), 0);
        check("rst_hlt", 32'(h4),   0);
        rst4 = 1'b0;

        // Ramen timer
        p4 = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
               8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
        load4();
        reset4();
        ce4  = 1'b1;
        rdy4 = 1'b1;
        for (int i = 0; i < 280; i++) begin
            prev = out4;
            tick();
            if (out4 !== prev) got_q.push_back(32'(out4));
        end
        exp_q.push_back(7);
        exp_q.push_back(6);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(0);
            exp_q.push_back(4);
        end
        exp_q.push_back(8);
        check("ramen_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("ramen_out", got_q[i], exp_q[i]);
        check("ramen_pc", 32'(pc4), 15);

        // SUB / JZ
        p4 = '{8'h32, 8'h83, 8'h32, 8'h82, 8'hA9, 8'hC0, 8'hC0, 8'hC0,
               8'hC0, 8'hD0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        load4();
        reset4();
        ce4 = 1'b1;
        tick();
        tick();
        check("sub3_a", 32'(u_d4.a_q), 15);
        check("sub3_c", 32'(u_d4.c_q), 0);
        check("sub3_z", 32'(u_d4.z_q), 0);
        tick();
        tick();
        check("sub2_a", 32'(u_d4.a_q), 0);
        check("sub2_c", 32'(u_d4.c_q), 1);
        check("sub2_z", 32'(u_d4.z_q), 1);
        tick();
        check("jz_pc", 32'(pc4), 9);
        tick();
        check("jz_hlt", 32'(h4), 1);

        // Output handshake stall
        p4 = '{8'hB5, 8'hB9, 8'hD0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0,
               8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        load4();
        reset4();
        rdy4 = 1'b0;
        ce4  = 1'b1;
        tick();
        check("hs1_ov",  32'(ov4),  1);
        check("hs1_out", 32'(out4), 5);
        tick();
        tick();
        check("hs_stall_pc",  32'(pc4),  1);
        check("hs_stall_out", 32'(out4), 5);
        rdy4 = 1'b1;
        tick();
        check("hs2_out", 32'(out4), 9);
        check("hs2_ov",  32'(ov4),  1);
        check("hs2_pc",  32'(pc4),  2);
        tick();
        check("hs_clr_ov", 32'(ov4), 0);

        // Halt / restart / reset-in-halt
        p4 = '{8'h39, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hD0, 8'hC0,
               8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        load4();
        reset4();
        ce4 = 1'b1;
        repeat (7) tick();
        check("hlt_h",  32'(h4),  1);
        check("hlt_pc", 32'(pc4), 6);
        for (int i = 0; i < 100; i++) begin
            ce4 = 1'($urandom);
            tick();
        end
        check("hlt_hold_h",  32'(h4),  1);
        check("hlt_hold_pc", 32'(pc4), 6);
        st4 = 1'b1;
        tick();
        st4 = 1'b0;
        check("start_pc", 32'(pc4),      0);
        check("start_h",  32'(h4),       0);
        check("start_a",  32'(u_d4.a_q), 9);
        ce4 = 1'b1;
        repeat (7) tick();
        check("hlt2_h", 32'(h4), 1);
        reset4();
        check("rsthlt_h",  32'(h4),       0);
        check("rsthlt_pc", 32'(pc4),      0);
        check("rsthlt_a",  32'(u_d4.a_q), 0);

        // Wide instance: carry at 8 bits, PC wrap, write to fetched address
        foreach (p8[i]) p8[i] = 0;
        p8[0] = 12'h301;
        p8[1] = 12'h0FF;
        p8[2] = 12'hF3F;
        ce4 = 1'b0;
        load8();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        ce8  = 1'b1;
        tick();
        tick();
        check("w_add_a", 32'(u_d8.a_q), 0);
        check("w_add_c", 32'(u_d8.c_q), 1);
        check("w_add_z", 32'(u_d8.z_q), 1);
        tick();
        check("w_jmp_pc", 32'(pc8), 63);
        tick();
        check("w_wrap_pc", 32'(pc8), 0);
        we8 = 1'b1;
        wa8 = 6'd0;
        wd8 = 12'h355;
        tick();
        we8 = 1'b0;
        check("w_old_a", 32'(u_d8.a_q), 1);
        repeat (4) tick();
        check("w_new_a", 32'(u_d8.a_q), 8'h55);
        ce8 = 1'b0;

        // Clock-enable pulsed every 4th cycle
        foreach (p4[i]) p4[i] = 8'h01;
        load4();
        reset4();
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            ce4  = (i % 4 == 0);
            rdy4 = 1'($urandom);
            prev = pc4;
            tick();
            if (pc4 !== prev) changes++;
        end
        check("ce_retires", changes, 10);

        // Randomised run on both instances
        foreach (p4[i]) p4[i] = $urandom & 8'hFF;
        foreach (p8[i]) p8[i] = $urandom & 12'hFFF;
        load4();
        load8();
        reset4();
        for (int i = 0; i < 1500; i++) begin
            rst4 = ($urandom % 200 == 0);
            ce4  = ($urandom % 4 != 0);
            rdy4 = 1'($urandom);
            st4  = ($urandom % 8 == 0);
            in4  = 4'($urandom);
            we4  = ($urandom % 16 == 0);
            wa4  = 4'($urandom);
            wd4  = 8'($urandom);
            rst8 = ($urandom % 200 == 0);
            ce8  = ($urandom % 4 != 0);
            rdy8 = 1'($urandom);
            st8  = ($urandom % 8 == 0);
            in8  = 8'($urandom);
            we8  = ($urandom % 16 == 0);
            wa8  = 6'($urandom);
            wd8  = 12'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/td4x_core.md
# td4x_core

Parametrised next-generation TD4-class 4-bit-style CPU core: two general registers A/B, carry and zero flags, writable instruction memory, configurable data and address width. It adds over the original core: a subtract, a jump-if-zero, a halt/restart mechanism, a clock-enable for slow stepping, and a valid/ready handshake on the output port. It sits between a board top (clock divider, LEDs, switches) and a host/loader that writes the program image.

## Interface
Parameters:
- DW, 4, data width of A, B, IN, OUT, immediate field; DW >= AW
- AW, 4, program-counter width; instruction memory depth 2**AW
- IW, 4+DW, instruction width (derived, not overridable): {OP[3:0], IM[DW-1:0]}

Ports:
- CLOCK  in  1  sole clock, all state on posedge
- RESET  in  1  synchronous, active-high reset
- CE  in  1  execute enable; instruction retires only in cycles with CE=1
- IN  in  DW  input port, sampled when IN A / IN B executes
- OUT  out  DW  output register
- OUT_VALID  out  1  OUT holds an unconsumed value
- OUT_READY  in  1  consumer accepts OUT this cycle (tie 1 for plain LED use)
- START  in  1  restart pulse, honoured only while halted
- HALTED  out  1  core in HALT state
- PC_O  out  AW  current program counter
- PROG_WE  in  1  instruction memory write strobe
- PROG_ADDR  in  AW  write address
- PROG_DATA  in  IW  write data

## Operation
- Fetch: combinational read ROM[PC]; OP=bits[IW-1:DW], IM=bits[DW-1:0]. ROM is not cleared by reset; power-up content is all zero (ADD A,0).
- Opcodes (TD4-compatible set plus extensions): 0000 ADD A,im; 0001 MOV A,B; 0010 IN A; 0011 MOV A,im; 0100 MOV B,A; 0101 ADD B,im; 0110 IN B; 0111 MOV B,im; 1001 OUT B; 1011 OUT im; 1110 JNC im; 1111 JMP im; new: 1000 SUB A,im; 1010 JZ im; 1100 NOP; 1101 HLT.
- ALU: {Cn,R} = src + IM in DW+1 bits, src per opcode (A, B, IN or 0). SUB: {Cn,R} = A + ~IM + 1, so C=1 means no borrow. MOV/IN/OUT/JMP/JNC/JZ also compute src+IM and update flags exactly like the original core.
- Flags: C<=Cn, Z<=(R==0) on every retired instruction except NOP, HLT and stalled OUT.
- Jumps: target = IM[AW-1:0]. JNC taken when C=0, JZ taken when Z=1, using flags from before this instruction; otherwise PC+1. PC wraps 2**AW-1 -> 0.
- States: RUN, HALT. RUN: on CE=1, retire one instruction. HLT -> HALT, PC unchanged, flags unchanged. HALT: nothing retires; START=1 -> RUN with PC=0, A/B/C/Z/OUT preserved. START ignored in RUN.
- Output handshake: an OUT instruction may retire only if OUT_VALID=0 or OUT_READY=1. Otherwise it stalls: PC, A, B, flags are held and it retries on each later CE cycle. On retire, OUT<=R and OUT_VALID<=1. OUT_VALID clears on OUT_READY=1 when no OUT retires that cycle. Simultaneous accept and new OUT: OUT_VALID stays 1 and OUT takes the new value.
- Program write: on PROG_WE=1, ROM[PROG_ADDR]<=PROG_DATA at the clock edge, in any state. Write to the address being fetched the same cycle: the old word executes and the new word is seen on the next fetch.

## Timing
- Reset (RESET=1 at posedge, overrides CE/START): A=B=0, C=Z=0, OUT=0, OUT_VALID=0, PC=0, state RUN, HALTED=0. A reset mid-stall or mid-halt has the same result.
- One instruction per CE=1 cycle; results are visible the cycle after the edge. No pipeline, no branch penalty.
- HALTED is asserted the cycle after HLT retires. START in cycle n gives PC_O=0 and HALTED=0 at n+1, and the first instruction retires at the first CE=1 edge at or after n+1.
- CE=0: all architectural state is frozen, except that OUT_VALID may still clear via OUT_READY, and ROM writes are still accepted.
- PC_O and HALTED are direct register outputs.

## Test plan
- DW=4, AW=4: load the 16-word ramen-timer program, OUT_READY=1, CE=1 -> OUT sequence 0111, 0110, 0000/0100 alternating, then 1000; PC sticks at 15.
- SUB A,3 with A=2 -> A=1111, C=0, Z=0. SUB A,2 with A=2 -> A=0, C=1, Z=1. Next JZ 5 -> PC=5.
- OUT_READY=0, two consecutive OUT im -> first retires (OUT_VALID=1), second stalls with PC held. Raise OUT_READY -> second retires the same cycle, OUT_VALID stays 1.
- HLT at PC=6 -> HALTED=1 with PC_O=6 for 100 cycles. START -> PC_O=0 next cycle, A unchanged. RESET during HALT -> all registers 0, running.
- DW=8, AW=6: ADD A,0xFF from A=1 -> A=0, C=1, Z=1. JMP 63 then ADD -> PC wraps to 0. PROG_WE at the fetched address -> old word executes once.
- CE pulsed every 4th cycle -> exactly one retire per pulse, and registers are unchanged between pulses.
